// File: rtl/aes_ctrl_seq.sv
// Round-sequencing controller for the masked AES-128 core.
// Produces one-cycle register enables, the round index, the last-round flag
// and the round constant that travel with the shares through the pipelined
// masked S-box. No share data passes through this block.
module aes_ctrl_seq #(
  parameter int NROUNDS = 10,
  parameter int SB_LAT  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       sel_init,
  output logic       en_state,
  output logic       en_key,
  output logic [3:0] round,
  output logic       last_round,
  output logic [7:0] rcon
);

  // Wait counter wide enough to hold SB_LAT, never narrower than one bit.
  localparam int CNT_W = ($clog2(SB_LAT + 1) < 1) ? 1 : $clog2(SB_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SB_LAT - 1);
  localparam logic [3:0]       ROUND_LAST = 4'(NROUNDS);
  localparam logic [7:0]       RCON_FIRST = 8'h01;

  // Parameter range guard, evaluated at elaboration.
  generate
    if (NROUNDS < 1 || NROUNDS > 15 || SB_LAT < 1 || SB_LAT > 31) begin : g_bad_params
      $fatal(1, "aes_ctrl_seq: NROUNDS must be 1..15 and SB_LAT 1..31");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_WAIT,
    ST_UPD,
    ST_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [3:0]       round_reg, round_next;
  logic [7:0]       rcon_reg, rcon_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // GF(2^8) multiply-by-two used to step the round constant.
  function automatic logic [7:0] xtime(input logic [7:0] v);
    logic [7:0] s;
    s = {v[6:0], 1'b0};
    if (v[7]) s = s ^ 8'h1B;
    return s;
  endfunction

  // State and sequencing registers; reset aborts any encryption in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      round_reg <= 4'd0;
      rcon_reg  <= RCON_FIRST;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      round_reg <= round_next;
      rcon_reg  <= rcon_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic and Moore outputs; in_ready is also held low while
  // reset is asserted so that no block can be accepted in the reset cycle.
  always_comb begin
    state_next = state_reg;
    round_next = round_reg;
    rcon_next  = rcon_reg;
    cnt_next   = cnt_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    sel_init   = 1'b0;
    en_state   = 1'b0;
    en_key     = 1'b0;
    last_round = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        in_ready = rst;
        if (in_valid && rst) state_next = ST_INIT;
      end
      ST_INIT: begin
        busy       = 1'b1;
        sel_init   = 1'b1;
        en_state   = 1'b1;
        en_key     = 1'b1;
        round_next = 4'd1;
        rcon_next  = RCON_FIRST;
        cnt_next   = '0;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        busy     = 1'b1;
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_LAST) state_next = ST_UPD;
      end
      ST_UPD: begin
        busy       = 1'b1;
        en_state   = 1'b1;
        en_key     = 1'b1;
        last_round = (round_reg == ROUND_LAST);
        if (round_reg == ROUND_LAST) begin
          state_next = ST_DONE;
        end else begin
          round_next = round_reg + 4'd1;
          rcon_next  = xtime(rcon_reg);
          cnt_next   = '0;
          state_next = ST_WAIT;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          round_next = 4'd0;
          rcon_next  = RCON_FIRST;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign round = round_reg;
  assign rcon  = rcon_reg;

endmodule
